// File: rtl/instr_encoder.sv
// RV32I instruction encoder: assembles instruction words from fields plus a class
// and streams them into instruction memory at sequential word addresses.
module instr_encoder #(
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH      = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [2:0]            in_type,
  input  logic [4:0]            in_rd,
  input  logic [4:0]            in_rs1,
  input  logic [4:0]            in_rs2,
  input  logic [2:0]            in_funct3,
  input  logic [6:0]            in_funct7,
  input  logic [31:0]           in_imm,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  err,
  output logic [1:0]            err_code,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full
);

  typedef enum logic [2:0] {
    T_R, T_I, T_LOAD, T_STORE, T_BRANCH, T_JAL, T_JALR, T_LUI
  } itype_e;

  typedef struct packed {
    itype_e      kind;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
  } fields_t;

  localparam logic [1:0] E_NONE  = 2'b00;
  localparam logic [1:0] E_RANGE = 2'b01;
  localparam logic [1:0] E_ALIGN = 2'b10;
  localparam logic [1:0] E_LUI   = 2'b11;

  localparam logic [ADDR_WIDTH+1:0] DEPTH_W = (ADDR_WIDTH+2)'(DEPTH);

  fields_t                 a_q;
  logic                    a_valid;
  logic [ADDR_WIDTH:0]     count_q;
  logic [31:0]             word;
  logic [1:0]              code;
  logic signed [31:0]      simm;
  logic                    accept;

  // Stage A occupancy counts against capacity so a full memory never gets an entry in flight.
  assign in_ready = !clear &&
                    (({1'b0, count_q} + {{(ADDR_WIDTH+1){1'b0}}, a_valid}) < DEPTH_W);
  assign accept   = in_valid && in_ready;
  assign count    = count_q;
  assign full     = ({1'b0, count_q} == DEPTH_W);
  assign simm     = $signed(a_q.imm);

  // NOTE: every output of a combinational block gets a default first so no path infers a latch.
  always_comb begin
    word = '0;
    code = E_NONE;
    unique case (a_q.kind)
      T_R: word = {a_q.funct7, a_q.rs2, a_q.rs1, a_q.funct3, a_q.rd, 7'b0110011};
      T_I, T_LOAD, T_JALR: begin
        word[31:20] = a_q.imm[11:0];
        word[19:15] = a_q.rs1;
        word[14:12] = (a_q.kind == T_JALR) ? 3'b000 : a_q.funct3;
        word[11:7]  = a_q.rd;
        word[6:0]   = (a_q.kind == T_I)    ? 7'b0010011 :
                      (a_q.kind == T_LOAD) ? 7'b0000011 : 7'b1100111;
        if (simm < -32'sd2048 || simm > 32'sd2047) code = E_RANGE;
      end
      T_STORE: begin
        word = {a_q.imm[11:5], a_q.rs2, a_q.rs1, a_q.funct3, a_q.imm[4:0], 7'b0100011};
        if (simm < -32'sd2048 || simm > 32'sd2047) code = E_RANGE;
      end
      T_BRANCH: begin
        word = {a_q.imm[12], a_q.imm[10:5], a_q.rs2, a_q.rs1, a_q.funct3,
                a_q.imm[4:1], a_q.imm[11], 7'b1100011};
        if (a_q.imm[0])                                code = E_ALIGN;
        else if (simm < -32'sd4096 || simm > 32'sd4094) code = E_RANGE;
      end
      T_JAL: begin
        word = {a_q.imm[20], a_q.imm[10:1], a_q.imm[11], a_q.imm[19:12], a_q.rd, 7'b1101111};
        if (a_q.imm[0])                                         code = E_ALIGN;
        else if (simm < -32'sd1048576 || simm > 32'sd1048574)   code = E_RANGE;
      end
      T_LUI: begin
        word = {a_q.imm[31:12], a_q.rd, 7'b0110111};
        if (a_q.imm[11:0] != 12'h000) code = E_LUI;
      end
      default: word = '0;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the stage A payload is reset too; it is small, and it keeps imem_wdata free of X after reset.
      a_valid    <= 1'b0;
      a_q        <= '0;
      count_q    <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      err        <= 1'b0;
      err_code   <= E_NONE;
    end else begin
      imem_we <= 1'b0;
      err     <= 1'b0;
      if (clear) begin
        a_valid <= 1'b0;
        count_q <= '0;
      end else begin
        a_valid <= accept;
        if (accept) begin
          a_q <= '{kind: itype_e'(in_type), rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                   funct3: in_funct3, funct7: in_funct7, imm: in_imm};
        end
        if (a_valid) begin
          if (code == E_NONE) begin
            imem_we    <= 1'b1;
            imem_addr  <= count_q[ADDR_WIDTH-1:0];
            imem_wdata <= word;
            count_q    <= count_q + (ADDR_WIDTH+1)'(1);
          end else begin
            err      <= 1'b1;
            err_code <= code;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: a behavioural model predicts each entry's
// write or error, and a monitor compares whatever the DUT presents.
module tb_instr_encoder;
  localparam int AW    = 4;
  localparam int DEPTH = 12;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clear = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [2:0]    in_type = '0;
  logic [4:0]    in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [2:0]    in_funct3 = '0;
  logic [6:0]    in_funct7 = '0;
  logic [31:0]   in_imm = '0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          err;
  logic [1:0]    err_code;
  logic [AW:0]   count;
  logic          full;

  instr_encoder #(.ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_type(in_type), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
    .in_funct3(in_funct3), .in_funct7(in_funct7), .in_imm(in_imm),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .err(err), .err_code(err_code), .count(count), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  t;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] imm;
  } fld_t;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    int          addr;
    logic [31:0] word;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_pass = 0;
  int          m_count = 0;
  bit          m_pend = 0;
  bit          m_pend_pass = 0;
  logic [1:0]  m_pend_code = 2'b00;
  logic [1:0]  m_last_code = 2'b00;
  int          bounds[12] = '{2047, 2048, -2048, -2049, 4094, 4096, -4096, -4098,
                              1048574, -1048576, 1048576, -1048578};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [31:0] fld(input logic [31:0] x, input int hi, input int lo);
    return (x >> lo) & ((32'h1 << (hi - lo + 1)) - 32'h1);
  endfunction

  function automatic fld_t mk(input int t, input int rd, input int rs1, input int rs2,
                              input int f3, input int f7, input logic [31:0] imm);
    fld_t f;
    f.t = 3'(t); f.rd = 5'(rd); f.rs1 = 5'(rs1); f.rs2 = 5'(rs2);
    f.f3 = 3'(f3); f.f7 = 7'(f7); f.imm = imm;
    return f;
  endfunction

  // Reference: place each field at its bit offset arithmetically, then apply the checks.
  function automatic void model(input fld_t f, output logic [1:0] code, output logic [31:0] w);
    longint v = longint'($signed(f.imm));
    longint lo = 0, hi = 0;
    bit     ranged = 1;
    logic [31:0] rd = 32'(f.rd), rs1 = 32'(f.rs1), rs2 = 32'(f.rs2);
    logic [31:0] f3 = 32'(f.f3), f7 = 32'(f.f7);
    code = 2'b00;
    case (f.t)
      3'd0: begin w = 32'd51 | rd << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | f7 << 25; ranged = 0; end
      3'd1, 3'd2, 3'd6: begin
        w = (f.t == 3'd1 ? 32'd19 : f.t == 3'd2 ? 32'd3 : 32'd103) | rd << 7 |
            (f.t == 3'd6 ? 32'd0 : f3 << 12) | rs1 << 15 | fld(f.imm, 11, 0) << 20;
        lo = -2048; hi = 2047;
      end
      3'd3: begin
        w = 32'd35 | fld(f.imm, 4, 0) << 7 | f3 << 12 | rs1 << 15 | rs2 << 20 | fld(f.imm, 11, 5) << 25;
        lo = -2048; hi = 2047;
      end
      3'd4: begin
        w = 32'd99 | fld(f.imm, 11, 11) << 7 | fld(f.imm, 4, 1) << 8 | f3 << 12 | rs1 << 15 |
            rs2 << 20 | fld(f.imm, 10, 5) << 25 | fld(f.imm, 12, 12) << 31;
        lo = -4096; hi = 4094;
      end
      3'd5: begin
        w = 32'd111 | rd << 7 | fld(f.imm, 19, 12) << 12 | fld(f.imm, 11, 11) << 20 |
            fld(f.imm, 10, 1) << 21 | fld(f.imm, 20, 20) << 31;
        lo = -1048576; hi = 1048574;
      end
      default: begin
        w = 32'd55 | rd << 7 | (f.imm & 32'hFFFFF000);
        ranged = 0;
        if ((f.imm & 32'hFFF) != 0) code = 2'b11;
      end
    endcase
    if ((f.t == 3'd4 || f.t == 3'd5) && (v % 2 != 0)) code = 2'b10;
    else if (ranged && (v < lo || v > hi))             code = 2'b01;
  endfunction

  // One clock cycle of stimulus; expectations are queued at the moment of acceptance.
  task automatic cycle(input bit v, input fld_t f, input bit c,
                       input bit use_exp, input logic [31:0] exp_w, input logic [1:0] exp_c);
    bit          rdy_exp, acc;
    logic [1:0]  code;
    logic [31:0] w;
    exp_t        e;
    @(negedge clk);
    in_valid = v; clear = c;
    in_type = f.t; in_rd = f.rd; in_rs1 = f.rs1; in_rs2 = f.rs2;
    in_funct3 = f.f3; in_funct7 = f.f7; in_imm = f.imm;
    #1;
    rdy_exp = !c && (m_count + int'(m_pend) < DEPTH);
    check("in_ready", 32'(in_ready), 32'(rdy_exp));
    check("count", 32'(count), 32'(m_count));
    check("full", 32'(full), 32'(m_count == DEPTH));
    check("err_code_held", 32'(err_code), 32'(m_last_code));
    acc = v && rdy_exp;
    model(f, code, w);
    if (use_exp) begin w = exp_w; code = exp_c; end
    if (acc) begin
      e.is_err = (code != 2'b00);
      e.code   = code;
      e.addr   = m_count + int'(m_pend && m_pend_pass);
      e.word   = w;
      sb.push_back(e);
    end
    @(posedge clk);
    if (c) begin
      if (m_pend) void'(sb.pop_back());
      m_pend  = 0;
      m_count = 0;
    end else begin
      if (m_pend) begin
        if (m_pend_pass) m_count++;
        else             m_last_code = m_pend_code;
      end
      m_pend      = acc;
      m_pend_pass = acc && (code == 2'b00);
      m_pend_code = code;
    end
  endtask

  task automatic idle();
    cycle(0, mk(0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0);
  endtask

  function automatic fld_t rand_fld();
    fld_t f;
    f.t = 3'($urandom_range(0, 7));
    f.rd = 5'($urandom); f.rs1 = 5'($urandom); f.rs2 = 5'($urandom);
    f.f3 = 3'($urandom); f.f7 = 7'($urandom);
    case ($urandom_range(0, 4))
      0: f.imm = 32'($signed($urandom_range(0, 40)) - 20);
      1: f.imm = 32'(bounds[$urandom_range(0, 11)]);
      2: f.imm = $urandom;
      3: f.imm = $urandom & 32'hFFFFF000;
      default: f.imm = 32'(($signed($urandom_range(0, 8191)) - 4096) * 2);
    endcase
    return f;
  endfunction

  task automatic mid_reset();
    @(negedge clk);
    in_valid = 0; clear = 0;
    #2 rst_n = 0;
    #1;
    check("rst_imem_we", 32'(imem_we), 0);
    check("rst_err", 32'(err), 0);
    check("rst_count", 32'(count), 0);
    check("rst_full", 32'(full), 0);
    check("rst_err_code", 32'(err_code), 0);
    sb.delete();
    m_count = 0; m_pend = 0; m_pend_pass = 0; m_last_code = 2'b00;
    @(negedge clk);
    rst_n = 1;
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n && (imem_we || err)) begin
      n_checks++;
      if (sb.size() == 0) begin
        $display("FAIL unexpected_output: got we=%0b err=%0b addr=%0d data=0x%08h expected nothing",
                 imem_we, err, imem_addr, imem_wdata);
      end else begin
        n_pass++;
        mon_e = sb.pop_front();
        check("kind", {30'd0, imem_we, err}, {30'd0, !mon_e.is_err, mon_e.is_err});
        if (mon_e.is_err) begin
          check("err_code", 32'(err_code), 32'(mon_e.code));
        end else begin
          check("imem_addr", 32'(imem_addr), 32'(mon_e.addr));
          check("imem_wdata", imem_wdata, mon_e.word);
        end
      end
    end
  end

  initial begin
    #3;
    check("reset_we", 32'(imem_we), 0);
    check("reset_err", 32'(err), 0);
    check("reset_count", 32'(count), 0);
    check("reset_full", 32'(full), 0);
    check("reset_wdata", imem_wdata, 0);
    #9 rst_n = 1;

    // add x3,x1,x2 then addi x1,x0,5 back-to-back
    cycle(1, mk(0, 3, 1, 2, 0, 0, 0), 0, 1, 32'h002081B3, 2'b00);
    cycle(1, mk(1, 1, 0, 0, 0, 0, 5), 0, 1, 32'h00500093, 2'b00);
    idle(); idle();
    cycle(0, mk(0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0);

    // lw, sw, beq, jal, lui at addresses 0..4
    cycle(1, mk(2, 2, 1, 0, 2, 0, 8), 0, 1, 32'h0080A103, 2'b00);
    cycle(1, mk(3, 0, 1, 2, 2, 0, 12), 0, 1, 32'h0020A623, 2'b00);
    cycle(1, mk(4, 0, 1, 2, 0, 0, -32'sd8), 0, 1, 32'hFE208CE3, 2'b00);
    cycle(1, mk(5, 1, 0, 0, 0, 0, 16), 0, 1, 32'h010000EF, 2'b00);
    cycle(1, mk(7, 5, 0, 0, 0, 0, 32'h12345000), 0, 1, 32'h123452B7, 2'b00);

    // Rejected entries, then the next good one lands at the unchanged address
    cycle(1, mk(4, 0, 1, 2, 0, 0, 3), 0, 1, 0, 2'b10);
    cycle(1, mk(1, 1, 0, 0, 0, 0, 4096), 0, 1, 0, 2'b01);
    cycle(1, mk(7, 5, 0, 0, 0, 0, 1), 0, 1, 0, 2'b11);
    cycle(1, mk(1, 1, 0, 0, 0, 0, 5), 0, 1, 32'h00500093, 2'b00);
    idle(); idle();

    // Clear right after an accept drops that entry
    cycle(1, mk(1, 1, 0, 0, 0, 0, 5), 0, 0, 0, 0);
    cycle(0, mk(0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0);
    cycle(1, mk(0, 3, 1, 2, 0, 0, 0), 0, 1, 32'h002081B3, 2'b00);
    idle();

    // Fill to DEPTH with in_valid held; extra entries are refused
    cycle(0, mk(0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0);
    for (int i = 0; i < DEPTH + 2; i++) cycle(1, mk(0, i, 1, 2, 0, 0, 0), 0, 0, 0, 0);
    idle();
    check("full_after_stream", 32'(full), 1);
    check("ready_when_full", 32'(in_ready), 0);
    cycle(0, mk(0, 0, 0, 0, 0, 0, 0), 1, 0, 0, 0);

    // Randomised traffic with occasional clears and one asynchronous reset
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        cycle(1, mk(0, 3, 1, 2, 0, 0, 0), 0, 0, 0, 0);
        mid_reset();
      end
      cycle($urandom_range(0, 3) != 0, rand_fld(), $urandom_range(0, 40) == 0, 0, 0, 0);
    end
    idle(); idle(); idle();
    check("scoreboard_drained", 32'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
